// File: rtl/gpio_buttons_pkg.sv
// Shared constants and types for the game-button GPIO peripheral.
package gpio_buttons_pkg;

  // Register offsets, decoded from iomem_addr[3:2]
  localparam logic [1:0] REG_STATE  = 2'd0;
  localparam logic [1:0] REG_EVENTS = 2'd1;
  localparam logic [1:0] REG_IRQ_EN = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  // Identification word ("BTN1") and the address byte the SoC top decodes
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4254_4E31;
  localparam logic [7:0]  BASE_SEL         = 8'h06;

  // Bus handshake: acknowledge once, then wait for the master to drop valid
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_HOLD = 2'd2
  } bus_state_t;

endpackage

// File: rtl/gpio_buttons_debounce.sv
// Single-button input path: 2-flop synchronizer, polarity fix, debounce.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic pad,
  output logic stable
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          pressed;
  logic [CW-1:0] count;

  // Synchronizer flops start at the released pad level so reset is not a press
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_a <= ACTIVE_LOW;
      sync_b <= ACTIVE_LOW;
    end else begin
      sync_a <= pad;
      sync_b <= sync_a;
    end
  end

  // 1 = pressed regardless of pad polarity
  assign pressed = sync_b ^ ACTIVE_LOW;

  // Accept a new level only after it has differed from stable for the full count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      stable <= 1'b0;
    end else if (pressed == stable) begin
      count <= '0;
    end else if (count == TERMINAL) begin
      stable <= pressed;
      count  <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_buttons.sv
// Button GPIO peripheral on the picosoc iomem bus: debounced state,
// sticky press events with write-one-to-clear, interrupt enable and ID.
module gpio_buttons
  import gpio_buttons_pkg::*;
#(
  parameter int          NUM_BUTTONS     = 8,
  parameter int          DEBOUNCE_CYCLES = 16000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter logic [31:0] ID_VALUE        = ID_VALUE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   iomem_valid,
  input  logic [3:0]             iomem_wstrb,
  input  logic [31:0]            iomem_addr,
  input  logic [31:0]            iomem_wdata,
  output logic                   iomem_ready,
  output logic [31:0]            iomem_rdata,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   irq
);

  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] stable_prev;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] events;
  logic [NUM_BUTTONS-1:0] irq_en;
  logic [NUM_BUTTONS-1:0] events_clr;
  bus_state_t             bus_state;
  logic                   accept;
  logic                   wr_en;
  logic [1:0]             reg_sel;
  logic [31:0]            wmask;
  logic [31:0]            wbits;
  logic [31:0]            rd_word;
  logic                   unused_bits;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_debounce (
      .clk   (clk),
      .resetn(resetn),
      .pad   (buttons[gi]),
      .stable(stable[gi])
    );
  end

  // A request is taken only from idle; register writes and the read sample happen on that edge
  assign accept  = iomem_valid && (bus_state == BUS_IDLE);
  assign wr_en   = accept && (|iomem_wstrb);
  assign reg_sel = iomem_addr[3:2];
  assign wmask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wbits   = iomem_wdata & wmask;
  assign rise    = stable & ~stable_prev;

  assign events_clr = (wr_en && reg_sel == REG_EVENTS) ? wbits[NUM_BUTTONS-1:0] : '0;

  // Address bits outside [3:2] and wdata bits beyond the button count are don't-cares
  assign unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0], wbits, wmask};

  // Read mux over pre-write register contents; bits above NUM_BUTTONS read 0
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_STATE:  rd_word = 32'(stable);
      REG_EVENTS: rd_word = 32'(events);
      REG_IRQ_EN: rd_word = 32'(irq_en);
      REG_ID:     rd_word = ID_VALUE;
      default:    rd_word = '0;
    endcase
  end

  // Sticky press events; a new press in the same cycle as its W1C keeps the bit set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_prev <= '0;
      events      <= '0;
    end else begin
      stable_prev <= stable;
      events      <= (events & ~events_clr) | rise;
    end
  end

  // Interrupt enable register with per-byte-lane writes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en <= '0;
    end else if (wr_en && reg_sel == REG_IRQ_EN) begin
      irq_en <= (irq_en & ~wmask[NUM_BUTTONS-1:0]) | wbits[NUM_BUTTONS-1:0];
    end
  end

  // Level interrupt from enabled pending events
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(events & irq_en);
    end
  end

  // Bus FSM: one-cycle ack with registered data, no re-ack until valid drops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_state   <= BUS_IDLE;
      iomem_rdata <= '0;
    end else begin
      iomem_rdata <= accept ? rd_word : '0;
      case (bus_state)
        BUS_IDLE: if (iomem_valid) bus_state <= BUS_ACK;
        BUS_ACK:  bus_state <= iomem_valid ? BUS_HOLD : BUS_IDLE;
        BUS_HOLD: if (!iomem_valid) bus_state <= BUS_IDLE;
        default:  bus_state <= BUS_IDLE;
      endcase
    end
  end

  assign iomem_ready = (bus_state == BUS_ACK);

endmodule

// File: tb/tb_gpio_buttons.sv
// Directed self-checking bench for gpio_buttons (DEBOUNCE_CYCLES=4, 8 buttons, active low).
module tb_gpio_buttons;

  localparam logic [31:0] ID_WORD = 32'h4254_4E31;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic [7:0]  buttons;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_buttons #(
    .NUM_BUTTONS    (8),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1),
    .ID_VALUE       (ID_WORD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready),
    .iomem_rdata(iomem_rdata),
    .buttons    (buttons),
    .irq        (irq)
  );

  task automatic check_equal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    iomem_addr  = addr;
    iomem_wstrb = 4'h0;
    iomem_wdata = 32'h0;
    iomem_valid = 1'b1;
    tick();
    check_equal("read_ack", {31'b0, iomem_ready}, 32'h1);
    data = iomem_rdata;
    iomem_valid = 1'b0;
    tick();
    $display("read  addr=0x%02h data=0x%08h", addr[7:0], data);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = data;
    iomem_valid = 1'b1;
    tick();
    check_equal("write_ack", {31'b0, iomem_ready}, 32'h1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    tick();
    $display("write addr=0x%02h data=0x%08h strb=%b", addr[7:0], data, strb);
  endtask

  task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check_equal(tag, d, exp);
  endtask

  initial begin
    logic [31:0] hold_data;
    int          pulses;

    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    buttons     = 8'hFF;
    repeat (3) tick();
    check_equal("rst_ready", {31'b0, iomem_ready}, 32'h0);
    check_equal("rst_rdata", iomem_rdata, 32'h0);
    check_equal("rst_irq", {31'b0, irq}, 32'h0);
    resetn = 1'b1;
    tick();
    read_expect("rst_state", 32'h0, 32'h0);
    read_expect("rst_events", 32'h4, 32'h0);
    read_expect("rst_irq_en", 32'h8, 32'h0);

    // ID read, then rdata must return to zero once ready drops
    read_expect("id", 32'hC, ID_WORD);
    check_equal("idle_ready", {31'b0, iomem_ready}, 32'h0);
    check_equal("idle_rdata", iomem_rdata, 32'h0);

    // Press bit 0: stable only after 6 edges from the pad change
    buttons = 8'hFE;
    repeat (5) tick();
    read_expect("state_early", 32'h0, 32'h0);
    read_expect("state_press", 32'h0, 32'h1);
    read_expect("events_press", 32'h4, 32'h1);

    // Three-cycle glitch on bit 1 is one short of acceptance
    buttons = 8'hFC;
    repeat (3) tick();
    buttons = 8'hFE;
    repeat (8) tick();
    read_expect("glitch_state", 32'h0, 32'h1);
    read_expect("glitch_events", 32'h4, 32'h1);

    // Enable IRQ, then clear the event
    check_equal("irq_off", {31'b0, irq}, 32'h0);
    bus_write(32'h8, 32'h1, 4'hF);
    check_equal("irq_on", {31'b0, irq}, 32'h1);
    bus_write(32'h4, 32'h1, 4'hF);
    check_equal("irq_cleared", {31'b0, irq}, 32'h0);
    read_expect("events_w1c", 32'h4, 32'h0);

    // W1C on bit 2 on the exact edge its event sets
    buttons = 8'hFA;
    repeat (6) tick();
    bus_write(32'h4, 32'h4, 4'hF);
    read_expect("race_events", 32'h4, 32'h4);
    check_equal("irq_masked", {31'b0, irq}, 32'h0);

    // valid held four cycles: a single ready pulse
    iomem_addr  = 32'h0;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    pulses      = 0;
    hold_data   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (iomem_ready) begin
        pulses++;
        hold_data = iomem_rdata;
      end
    end
    iomem_valid = 1'b0;
    tick();
    $display("hold  addr=0x00 data=0x%08h pulses=%0d", hold_data, pulses);
    check_equal("hold_pulses", pulses, 32'd1);
    check_equal("hold_data", hold_data, 32'h5);

    // Read-only registers ignore writes
    bus_write(32'h0, 32'hFF, 4'hF);
    read_expect("state_ro", 32'h0, 32'h5);
    bus_write(32'hC, 32'h0, 4'hF);
    read_expect("id_ro", 32'hC, ID_WORD);

    // Byte-lane writes to IRQ_EN; lane 1 is beyond the implemented bits
    bus_write(32'h8, 32'h0000_00F0, 4'b0001);
    read_expect("lane0", 32'h8, 32'hF0);
    bus_write(32'h8, 32'hFFFF_FFFF, 4'b0010);
    read_expect("lane1", 32'h8, 32'hF0);
    bus_write(32'h8, 32'h4, 4'hF);
    check_equal("irq_bit2", {31'b0, irq}, 32'h1);

    // Reset while an acknowledge is on the bus
    iomem_addr  = 32'hC;
    iomem_valid = 1'b1;
    tick();
    check_equal("pend_ack", {31'b0, iomem_ready}, 32'h1);
    resetn = 1'b0;
    #1;
    check_equal("mid_rst_ready", {31'b0, iomem_ready}, 32'h0);
    check_equal("mid_rst_rdata", iomem_rdata, 32'h0);
    check_equal("mid_rst_irq", {31'b0, irq}, 32'h0);
    iomem_valid = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    read_expect("post_state", 32'h0, 32'h0);
    read_expect("post_events", 32'h4, 32'h0);
    read_expect("post_irq_en", 32'h8, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
